// File: rtl/router_controller_fwd.sv
// Per-node router controller: local TX sequencing and link RX
// decap/deliver/forward/drop, with packet counter and wait timeout.
module router_controller_fwd #(
  parameter int ADDR_WIDTH             = 10,
  parameter int NUMBER_PACKET          = 19,
  parameter int RECOGNIZE_ROUTER_WIDTH = 2,
  parameter int TTL_WIDTH              = 2,
  parameter int TTL_INIT               = 3,
  parameter int ROUTER_ID              = 0,
  parameter int TIMEOUT_CYCLES         = 255,
  localparam int PN_W  = $clog2(NUMBER_PACKET),
  localparam int RW    = RECOGNIZE_ROUTER_WIDTH,
  localparam int HDR_W = TTL_WIDTH + RW + PN_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  router_start_req,
  input  logic [ADDR_WIDTH-1:0] router_scr_addr,
  input  logic [ADDR_WIDTH-1:0] router_dst_addr,
  output logic                  router_done,
  output logic                  router_busy,
  output logic                  router_error,
  output logic                  pkt_drop,
  output logic                  arbiter_read_req,
  output logic                  arbiter_write_req,
  input  logic                  arbiter_read_gnt,
  input  logic                  arbiter_write_gnt,
  output logic [ADDR_WIDTH-1:0] arbiter_src_addr,
  output logic [ADDR_WIDTH-1:0] arbiter_dst_addr,
  output logic [1:0]            control_crossbar,
  output logic                  start_encap_pkt,
  input  logic                  encap_done,
  output logic [HDR_W-1:0]      header_pkt_send,
  output logic [ADDR_WIDTH-1:0] router_dst_addr_send,
  input  logic                  empty_input_port_0,
  output logic                  rd_input_port_0,
  input  logic                  empty_input_port_1,
  output logic                  rd_input_port_1,
  output logic                  start_decap_pkt,
  input  logic                  decap_done,
  input  logic [HDR_W-1:0]      header_pkt_recv,
  input  logic [ADDR_WIDTH-1:0] dst_addr_arbiter_recv,
  output logic                  we_output_port_0,
  output logic                  we_output_port_1
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_TX_ARB, S_TX_ESTART, S_TX_ENC,
    S_TX_DRAIN, S_TX_DONE, S_RX_DSTART, S_RX_DEC,
    S_RX_WARB, S_RX_LDRAIN, S_RX_FSTART, S_RX_FENC,
    S_RX_FDRAIN, S_RX_DROP, S_RX_DONE
  } state_t;

  state_t state, next;

  logic [TW-1:0]         tcnt;
  logic                  rd_q;
  logic                  cnt_en;
  logic                  tmo;
  logic [ADDR_WIDTH-1:0] src_q, dst_q;
  logic [HDR_W-1:0]      hdr_q;
  logic [PN_W-1:0]       pn;

  logic [TTL_WIDTH-1:0]      rx_ttl;
  logic [HDR_W-TTL_WIDTH-1:0] rx_rest;
  logic                      rx_local;

  assign rx_ttl   = header_pkt_recv[HDR_W-1 -: TTL_WIDTH];
  assign rx_rest  = header_pkt_recv[HDR_W-TTL_WIDTH-1:0];
  assign rx_local =
    dst_addr_arbiter_recv[ADDR_WIDTH-1 -: RW] == RW'(ROUTER_ID);
  assign tmo = (tcnt == TW'(TIMEOUT_CYCLES));

  assign router_busy          = (state != S_IDLE);
  assign arbiter_src_addr     = src_q;
  assign arbiter_dst_addr     = dst_q;
  assign router_dst_addr_send = dst_q;
  assign header_pkt_send      = hdr_q;

  always_comb begin
    next              = state;
    cnt_en            = 1'b0;
    router_done       = 1'b0;
    router_error      = 1'b0;
    pkt_drop          = 1'b0;
    arbiter_read_req  = 1'b0;
    arbiter_write_req = 1'b0;
    control_crossbar  = 2'b00;
    start_encap_pkt   = 1'b0;
    start_decap_pkt   = 1'b0;
    rd_input_port_0   = 1'b0;
    rd_input_port_1   = 1'b0;
    we_output_port_0  = 1'b0;
    we_output_port_1  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty_input_port_1)   next = S_RX_DSTART;
        else if (router_start_req) next = S_TX_ARB;
      end
      S_TX_ARB: begin
        cnt_en           = 1'b1;
        arbiter_read_req = !tmo;
        if (tmo) begin
          router_error = 1'b1;
          next         = S_IDLE;
        end else if (arbiter_read_gnt) begin
          next = S_TX_ESTART;
        end
      end
      S_TX_ESTART: begin
        start_encap_pkt = 1'b1;
        next            = S_TX_ENC;
      end
      S_TX_ENC: begin
        cnt_en = 1'b1;
        if (encap_done) next = S_TX_DRAIN;
        else if (tmo) begin
          router_error = 1'b1;
          next         = S_IDLE;
        end
      end
      S_TX_DRAIN: begin
        control_crossbar = 2'b01;
        rd_input_port_0  = !empty_input_port_0;
        we_output_port_1 = rd_q;
        if (empty_input_port_0 && !rd_q) next = S_TX_DONE;
      end
      S_TX_DONE, S_RX_DONE: begin
        router_done = 1'b1;
        next        = S_IDLE;
      end
      S_RX_DSTART: begin
        start_decap_pkt = 1'b1;
        next            = S_RX_DEC;
      end
      S_RX_DEC: begin
        cnt_en = 1'b1;
        if (decap_done) begin
          if (rx_local)          next = S_RX_WARB;
          else if (rx_ttl == '0) next = S_RX_DROP;
          else                   next = S_RX_FSTART;
        end else if (tmo) begin
          router_error = 1'b1;
          next         = S_IDLE;
        end
      end
      S_RX_WARB: begin
        cnt_en            = 1'b1;
        arbiter_write_req = !tmo;
        if (tmo) begin
          router_error = 1'b1;
          next         = S_IDLE;
        end else if (arbiter_write_gnt) begin
          next = S_RX_LDRAIN;
        end
      end
      S_RX_LDRAIN: begin
        control_crossbar = 2'b10;
        rd_input_port_1  = !empty_input_port_1;
        we_output_port_0 = rd_q;
        if (empty_input_port_1 && !rd_q) next = S_RX_DONE;
      end
      S_RX_FSTART: begin
        start_encap_pkt = 1'b1;
        next            = S_RX_FENC;
      end
      S_RX_FENC: begin
        cnt_en = 1'b1;
        if (encap_done) next = S_RX_FDRAIN;
        else if (tmo) begin
          router_error = 1'b1;
          next         = S_IDLE;
        end
      end
      S_RX_FDRAIN: begin
        control_crossbar = 2'b11;
        rd_input_port_1  = !empty_input_port_1;
        we_output_port_1 = rd_q;
        if (empty_input_port_1 && !rd_q) next = S_RX_DONE;
      end
      S_RX_DROP: begin
        rd_input_port_1 = !empty_input_port_1;
        if (empty_input_port_1 && !rd_q) begin
          pkt_drop = 1'b1;
          next     = S_IDLE;
        end
      end
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      tcnt  <= '0;
      rd_q  <= 1'b0;
      src_q <= '0;
      dst_q <= '0;
      hdr_q <= '0;
      pn    <= '0;
    end else begin
      state <= next;
      rd_q  <= rd_input_port_0 | rd_input_port_1;
      if (next != state) tcnt <= '0;
      else if (cnt_en)   tcnt <= tcnt + 1'b1;
      if (state == S_IDLE && next == S_TX_ARB) begin
        src_q <= router_scr_addr;
        dst_q <= router_dst_addr;
        hdr_q <= {TTL_WIDTH'(TTL_INIT), RW'(ROUTER_ID), pn};
      end
      if (state == S_RX_DEC && decap_done) begin
        dst_q <= dst_addr_arbiter_recv;
        // forwarded packets lose one hop of lifetime
        if (!rx_local && rx_ttl != '0)
          hdr_q <= {rx_ttl - 1'b1, rx_rest};
        else
          hdr_q <= header_pkt_recv;
      end
      if (state == S_TX_DONE)
        pn <= (pn == PN_W'(NUMBER_PACKET - 1)) ? '0 : pn + 1'b1;
    end
  end

endmodule

// File: tb/tb_router_controller_fwd.sv
// Directed bench for router_controller_fwd with simple FIFO
// occupancy models on both input ports.
module tb_router_controller_fwd;

  localparam int AW = 10;
  localparam int HW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          router_start_req = 1'b0;
  logic [AW-1:0] router_scr_addr = '0;
  logic [AW-1:0] router_dst_addr = '0;
  logic          router_done, router_busy, router_error, pkt_drop;
  logic          arbiter_read_req, arbiter_write_req;
  logic          arbiter_read_gnt = 1'b0;
  logic          arbiter_write_gnt = 1'b0;
  logic [AW-1:0] arbiter_src_addr, arbiter_dst_addr;
  logic [1:0]    control_crossbar;
  logic          start_encap_pkt;
  logic          encap_done = 1'b0;
  logic [HW-1:0] header_pkt_send;
  logic [AW-1:0] router_dst_addr_send;
  logic          empty_input_port_0, rd_input_port_0;
  logic          empty_input_port_1, rd_input_port_1;
  logic          start_decap_pkt;
  logic          decap_done = 1'b0;
  logic [HW-1:0] header_pkt_recv = '0;
  logic [AW-1:0] dst_addr_arbiter_recv = '0;
  logic          we_output_port_0, we_output_port_1;

  int push0 = 0, pop0 = 0, push1 = 0, pop1 = 0;
  int we0_n = 0, we1_n = 0, done_n = 0, drop_n = 0;
  int checks = 0, errors = 0;

  assign empty_input_port_0 = (push0 == pop0);
  assign empty_input_port_1 = (push1 == pop1);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_input_port_0)  pop0   <= pop0 + 1;
    if (rd_input_port_1)  pop1   <= pop1 + 1;
    if (we_output_port_0) we0_n  <= we0_n + 1;
    if (we_output_port_1) we1_n  <= we1_n + 1;
    if (router_done)      done_n <= done_n + 1;
    if (pkt_drop)         drop_n <= drop_n + 1;
  end

  router_controller_fwd dut (
    .clk(clk), .rst_n(rst_n),
    .router_start_req(router_start_req),
    .router_scr_addr(router_scr_addr),
    .router_dst_addr(router_dst_addr),
    .router_done(router_done), .router_busy(router_busy),
    .router_error(router_error), .pkt_drop(pkt_drop),
    .arbiter_read_req(arbiter_read_req),
    .arbiter_write_req(arbiter_write_req),
    .arbiter_read_gnt(arbiter_read_gnt),
    .arbiter_write_gnt(arbiter_write_gnt),
    .arbiter_src_addr(arbiter_src_addr),
    .arbiter_dst_addr(arbiter_dst_addr),
    .control_crossbar(control_crossbar),
    .start_encap_pkt(start_encap_pkt), .encap_done(encap_done),
    .header_pkt_send(header_pkt_send),
    .router_dst_addr_send(router_dst_addr_send),
    .empty_input_port_0(empty_input_port_0),
    .rd_input_port_0(rd_input_port_0),
    .empty_input_port_1(empty_input_port_1),
    .rd_input_port_1(rd_input_port_1),
    .start_decap_pkt(start_decap_pkt), .decap_done(decap_done),
    .header_pkt_recv(header_pkt_recv),
    .dst_addr_arbiter_recv(dst_addr_arbiter_recv),
    .we_output_port_0(we_output_port_0),
    .we_output_port_1(we_output_port_1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_tx(input logic [AW-1:0] s, input logic [AW-1:0] d,
                        input int nw, input int gd,
                        input logic [HW-1:0] exp_hdr);
    int p0, w1, n;
    bit seen;
    p0 = pop0;
    w1 = we1_n;
    push0 += nw;
    router_scr_addr  = s;
    router_dst_addr  = d;
    router_start_req = 1'b1;
    tick;
    router_start_req = 1'b0;
    chk("tx_busy", 32'(router_busy), 32'd1);
    chk("tx_src", 32'(arbiter_src_addr), 32'(s));
    chk("tx_dst", 32'(arbiter_dst_addr), 32'(d));
    n = 0;
    repeat (gd) begin
      if (arbiter_read_req) n++;
      tick;
    end
    chk("tx_req_held", 32'(n), 32'(gd));
    arbiter_read_gnt = 1'b1;
    #1;
    chk("tx_req_at_gnt", 32'(arbiter_read_req), 32'd1);
    tick;
    arbiter_read_gnt = 1'b0;
    chk("tx_encap_start", 32'(start_encap_pkt), 32'd1);
    chk("tx_hdr", 32'(header_pkt_send), 32'(exp_hdr));
    chk("tx_dst_send", 32'(router_dst_addr_send), 32'(d));
    tick;
    chk("tx_encap_pulse", 32'(start_encap_pkt), 32'd0);
    chk("tx_xbar_wait", 32'(control_crossbar), 32'd0);
    encap_done = 1'b1;
    tick;
    encap_done = 1'b0;
    chk("tx_xbar_drain", 32'(control_crossbar), 32'd1);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (router_done) begin
        seen = 1'b1;
        break;
      end
      tick;
    end
    chk("tx_done", 32'(seen), 32'd1);
    chk("tx_words_out1", 32'(we1_n - w1), 32'(nw));
    chk("tx_reads_in0", 32'(pop0 - p0), 32'(nw));
    tick;
    chk("tx_idle", 32'(router_busy), 32'd0);
  endtask

  initial begin
    int n, w0, w1, p1, d0, dr0;
    bit seen;

    // reset
    #2;
    chk("rst_busy", 32'(router_busy), 32'd0);
    chk("rst_req", 32'({arbiter_read_req, arbiter_write_req}), 32'd0);
    chk("rst_hdr", 32'(header_pkt_send), 32'd0);
    chk("rst_addr", 32'(arbiter_src_addr), 32'd0);
    chk("rst_pulses", 32'({router_done, router_error, pkt_drop}), 32'd0);
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    chk("idle_busy", 32'(router_busy), 32'd0);

    // first TX packet, grant after 3 cycles, 4 words
    run_tx(10'h010, 10'h2A0, 4, 3, 9'h180);

    // packets with pn 1..18, then wrap to 0
    for (int i = 1; i < 19; i++)
      run_tx(10'(i), 10'h2A0, 1 + (i % 3), i % 4, 9'h180 | 9'(i));
    run_tx(10'h011, 10'h0F0, 2, 0, 9'h180);

    // RX local delivery; a simultaneous TX request loses
    w0 = we0_n;
    w1 = we1_n;
    p1 = pop1;
    d0 = done_n;
    push1 += 3;
    router_start_req = 1'b1;
    router_scr_addr  = 10'h033;
    tick;
    router_start_req = 1'b0;
    chk("rxl_decap_start", 32'(start_decap_pkt), 32'd1);
    chk("rxl_no_rdreq", 32'(arbiter_read_req), 32'd0);
    tick;
    chk("rxl_decap_pulse", 32'(start_decap_pkt), 32'd0);
    decap_done            = 1'b1;
    header_pkt_recv       = 9'h123;
    dst_addr_arbiter_recv = 10'h055;
    tick;
    decap_done = 1'b0;
    chk("rxl_wreq", 32'(arbiter_write_req), 32'd1);
    chk("rxl_xbar_wait", 32'(control_crossbar), 32'd0);
    chk("rxl_rx_dst", 32'(arbiter_dst_addr), 32'h055);
    tick;
    chk("rxl_wreq_held", 32'(arbiter_write_req), 32'd1);
    arbiter_write_gnt = 1'b1;
    tick;
    arbiter_write_gnt = 1'b0;
    chk("rxl_xbar", 32'(control_crossbar), 32'd2);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (router_done) begin
        seen = 1'b1;
        break;
      end
      tick;
    end
    chk("rxl_done", 32'(seen), 32'd1);
    chk("rxl_words_out0", 32'(we0_n - w0), 32'd3);
    chk("rxl_words_out1", 32'(we1_n - w1), 32'd0);
    chk("rxl_reads_in1", 32'(pop1 - p1), 32'd3);
    tick;
    chk("rxl_idle", 32'(router_busy), 32'd0);
    chk("rxl_one_done", 32'(done_n - d0), 32'd1);

    // RX forward with TTL decrement
    w0 = we0_n;
    w1 = we1_n;
    p1 = pop1;
    push1 += 2;
    tick;
    chk("rxf_decap_start", 32'(start_decap_pkt), 32'd1);
    tick;
    decap_done            = 1'b1;
    header_pkt_recv       = 9'h1C5;
    dst_addr_arbiter_recv = 10'h2A0;
    tick;
    decap_done = 1'b0;
    chk("rxf_encap_start", 32'(start_encap_pkt), 32'd1);
    chk("rxf_hdr", 32'(header_pkt_send), 32'h145);
    chk("rxf_dst_send", 32'(router_dst_addr_send), 32'h2A0);
    chk("rxf_no_wreq", 32'(arbiter_write_req), 32'd0);
    tick;
    chk("rxf_encap_pulse", 32'(start_encap_pkt), 32'd0);
    encap_done = 1'b1;
    tick;
    encap_done = 1'b0;
    chk("rxf_xbar", 32'(control_crossbar), 32'd3);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (router_done) begin
        seen = 1'b1;
        break;
      end
      tick;
    end
    chk("rxf_done", 32'(seen), 32'd1);
    chk("rxf_words_out1", 32'(we1_n - w1), 32'd2);
    chk("rxf_words_out0", 32'(we0_n - w0), 32'd0);
    chk("rxf_reads_in1", 32'(pop1 - p1), 32'd2);
    tick;

    // RX drop on expired TTL
    w0  = we0_n;
    w1  = we1_n;
    p1  = pop1;
    d0  = done_n;
    dr0 = drop_n;
    push1 += 3;
    tick;
    tick;
    decap_done            = 1'b1;
    header_pkt_recv       = 9'h027;
    dst_addr_arbiter_recv = 10'h300;
    tick;
    decap_done = 1'b0;
    chk("drop_xbar", 32'(control_crossbar), 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (pkt_drop) begin
        seen = 1'b1;
        break;
      end
      tick;
    end
    chk("drop_pulse", 32'(seen), 32'd1);
    chk("drop_reads_in1", 32'(pop1 - p1), 32'd3);
    chk("drop_no_writes", 32'((we0_n - w0) + (we1_n - w1)), 32'd0);
    tick;
    chk("drop_idle", 32'(router_busy), 32'd0);
    chk("drop_no_done", 32'(done_n - d0), 32'd0);
    chk("drop_one_pulse", 32'(drop_n - dr0), 32'd1);

    // grant withheld -> timeout
    d0 = done_n;
    router_scr_addr  = 10'h001;
    router_dst_addr  = 10'h102;
    router_start_req = 1'b1;
    tick;
    router_start_req = 1'b0;
    n    = 0;
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (router_error) begin
        seen = 1'b1;
        break;
      end
      if (arbiter_read_req) n++;
      tick;
    end
    chk("tmo_error", 32'(seen), 32'd1);
    chk("tmo_req_cycles", 32'(n), 32'd255);
    chk("tmo_req_dropped", 32'(arbiter_read_req), 32'd0);
    tick;
    chk("tmo_idle", 32'(router_busy), 32'd0);
    chk("tmo_error_pulse", 32'(router_error), 32'd0);
    chk("tmo_no_done", 32'(done_n - d0), 32'd0);

    // reset mid-drain (pkt_number is 1 here)
    push0 += 6;
    router_scr_addr  = 10'h044;
    router_dst_addr  = 10'h155;
    router_start_req = 1'b1;
    tick;
    router_start_req = 1'b0;
    arbiter_read_gnt = 1'b1;
    tick;
    arbiter_read_gnt = 1'b0;
    chk("mid_hdr", 32'(header_pkt_send), 32'h181);
    tick;
    encap_done = 1'b1;
    tick;
    encap_done = 1'b0;
    tick;
    chk("mid_draining", 32'(rd_input_port_0), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(router_busy), 32'd0);
    chk("mid_rst_rd", 32'(rd_input_port_0), 32'd0);
    chk("mid_rst_we", 32'({we_output_port_0, we_output_port_1}), 32'd0);
    chk("mid_rst_xbar", 32'(control_crossbar), 32'd0);
    chk("mid_rst_hdr", 32'(header_pkt_send), 32'd0);
    chk("mid_rst_pulses", 32'({router_done, router_error}), 32'd0);
    tick;
    push0 = pop0;
    rst_n = 1'b1;
    tick;
    run_tx(10'h066, 10'h377, 2, 1, 9'h180);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
